ex2mem_reg: RTL and testbench

EX2MEM_REG -- requirements
Module: ex2mem_reg

---
 rtl/ex2mem_reg.sv | 149 ++++++++++++++
 tb/tb_ex2mem_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex2mem_reg.sv
// ex2mem_reg: EX->MEM pipeline register with a data-memory access FSM and timeout abort.
// Optional build macro STALL_CNT_EN adds a 32-bit stall_cnt output counting stalled cycles.
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif
`ifndef WB_SRC_WIDTH
`define WB_SRC_WIDTH 2
`endif
`ifndef WB_SRC_MEM
`define WB_SRC_MEM 2'd1
`endif

// Handshake: a memory op captured into the register raises mem_req from the next cycle;
// the access completes in the first WAIT cycle that sees mem_ready, and the register may
// load again at the end of that same cycle (ex_stall is low while mem_ready is high).
module ex2mem_reg #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef STALL_CNT_EN
    output logic [31:0]               stall_cnt,
`endif
    input  logic                      ex_valid,
    input  logic [31:0]               ex_alu_result,
    input  logic [`REGADDR_WIDTH-1:0] ex_wb_reg_addr,
    input  logic [`WB_SRC_WIDTH-1:0]  ex_wb_src,
    input  logic                      ex_mem_wr,
    input  logic [31:0]               ex_store_data,
    input  logic                      flush,
    input  logic                      mem_ready,
    input  logic [`REGADDR_WIDTH-1:0] alu_opr_reg_addr,
    output logic                      ex2mem_valid,
    output logic [31:0]               ex2mem_alu_result,
    output logic [`REGADDR_WIDTH-1:0] ex2mem_wb_reg_addr,
    output logic [`WB_SRC_WIDTH-1:0]  ex2mem_wb_src,
    output logic                      ex2mem_mem_wr,
    output logic [31:0]               ex2mem_store_data,
    output logic                      mem_req,
    output logic                      ex_stall,
    output logic                      load_hazard,
    output logic                      mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Index of the last WAIT cycle before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [7:0]                  r_timer;
    logic [7:0]                  w_timer_nxt;
    logic                        r_valid;
    logic [31:0]                 r_alu_result;
    logic [`REGADDR_WIDTH-1:0]   r_wb_reg_addr;
    logic [`WB_SRC_WIDTH-1:0]    r_wb_src;
    logic                        r_mem_wr;
    logic [31:0]                 r_store_data;
    logic                        w_timeout_hit;
    logic                        w_stall;
    logic                        w_load_valid;
    logic                        w_load_mem;

    assign w_timeout_hit = (r_state == S_WAIT) && !mem_ready && (r_timer == TIMEOUT_LAST);
    assign w_stall       = (r_state == S_WAIT) && !mem_ready && !w_timeout_hit;
    assign w_load_valid  = ex_valid && !flush;
    assign w_load_mem    = w_load_valid && ((ex_wb_src == `WB_SRC_MEM) || ex_mem_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (w_stall) begin
            w_timer_nxt = r_timer + 8'd1;
        end else begin
            w_timer_nxt = '0;
            w_state_nxt = w_load_mem ? S_WAIT : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_alu_result  <= '0;
            r_wb_reg_addr <= '0;
            r_wb_src      <= '0;
            r_mem_wr      <= 1'b0;
            r_store_data  <= '0;
        end else if (!w_stall) begin
            if (w_load_valid) begin
                r_valid       <= 1'b1;
                r_alu_result  <= ex_alu_result;
                r_wb_reg_addr <= ex_wb_reg_addr;
                r_wb_src      <= ex_wb_src;
                r_mem_wr      <= ex_mem_wr;
                r_store_data  <= ex_store_data;
            end else begin
                r_valid       <= 1'b0;
                r_alu_result  <= '0;
                r_wb_reg_addr <= '0;
                r_wb_src      <= '0;
                r_mem_wr      <= 1'b0;
                r_store_data  <= '0;
            end
        end
    end

    // A timed-out entry reads as a bubble during its final cycle so nothing downstream consumes it.
    assign ex2mem_valid       = r_valid && !w_timeout_hit;
    assign ex2mem_wb_reg_addr = w_timeout_hit ? '0 : r_wb_reg_addr;
    assign ex2mem_alu_result  = r_alu_result;
    assign ex2mem_wb_src      = r_wb_src;
    assign ex2mem_mem_wr      = r_mem_wr;
    assign ex2mem_store_data  = r_store_data;
    assign mem_req            = (r_state == S_WAIT);
    assign ex_stall           = w_stall;
    assign mem_err            = w_timeout_hit;
    assign load_hazard        = ex2mem_valid && (ex2mem_wb_src == `WB_SRC_MEM) &&
                                (ex2mem_wb_reg_addr == alu_opr_reg_addr) &&
                                (alu_opr_reg_addr != '0);

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex2mem_reg.sv
// tb_ex2mem_reg: directed and random stimulus for ex2mem_reg against a cycle-level reference model.
// Build with STALL_CNT_EN defined to also check the stall counter.
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif
`ifndef WB_SRC_WIDTH
`define WB_SRC_WIDTH 2
`endif
`ifndef WB_SRC_MEM
`define WB_SRC_MEM 2'd1
`endif

module tb_ex2mem_reg;
    localparam int TO = 4;
    localparam int AW = `REGADDR_WIDTH;
    localparam int SW = `WB_SRC_WIDTH;
    localparam logic [SW-1:0] SRC_ALU = '0;
    localparam logic [SW-1:0] SRC_MEM = `WB_SRC_MEM;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, ex_mem_wr, flush, mem_ready;
    logic [31:0]   ex_alu_result, ex_store_data;
    logic [AW-1:0] ex_wb_reg_addr, alu_opr_reg_addr;
    logic [SW-1:0] ex_wb_src;
    logic          ex2mem_valid, ex2mem_mem_wr, mem_req, ex_stall, load_hazard, mem_err;
    logic [31:0]   ex2mem_alu_result, ex2mem_store_data;
    logic [AW-1:0] ex2mem_wb_reg_addr;
    logic [SW-1:0] ex2mem_wb_src;
`ifdef STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    ex2mem_reg #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_wb_reg_addr(ex_wb_reg_addr),
        .ex_wb_src(ex_wb_src), .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data),
        .flush(flush), .mem_ready(mem_ready), .alu_opr_reg_addr(alu_opr_reg_addr),
        .ex2mem_valid(ex2mem_valid), .ex2mem_alu_result(ex2mem_alu_result),
        .ex2mem_wb_reg_addr(ex2mem_wb_reg_addr), .ex2mem_wb_src(ex2mem_wb_src),
        .ex2mem_mem_wr(ex2mem_mem_wr), .ex2mem_store_data(ex2mem_store_data),
        .mem_req(mem_req), .ex_stall(ex_stall), .load_hazard(load_hazard), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction held in the stage, whether its memory access is
    // still outstanding, and how many cycles that access has already waited.
    logic          m_valid, m_wr, m_busy;
    logic [31:0]   m_alu, m_sd, m_stall_total;
    logic [AW-1:0] m_addr;
    logic [SW-1:0] m_src;
    int            m_waited;

    logic s_valid, s_req, s_stall, s_err, s_hazard;
    logic [AW-1:0] s_addr;
    int   n_req, n_stall, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_wr = 1'b0; m_busy = 1'b0; m_alu = '0; m_sd = '0;
        m_addr = '0; m_src = '0; m_waited = 0; m_stall_total = '0;
    endtask

    task automatic drive(input logic v, input logic fl, input int addr, input logic [SW-1:0] src,
                         input logic wr, input logic [31:0] alu, input logic [31:0] sd,
                         input logic rdy, input int opr);
        ex_valid = v; flush = fl; ex_wb_reg_addr = AW'(addr); ex_wb_src = src;
        ex_mem_wr = wr; ex_alu_result = alu; ex_store_data = sd; mem_ready = rdy;
        alu_opr_reg_addr = AW'(opr);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        logic to, e_stall, e_valid, e_haz;
        logic [AW-1:0] e_addr;
        @(negedge clk); #1;
        s_valid = ex2mem_valid; s_req = mem_req; s_stall = ex_stall; s_err = mem_err;
        s_hazard = load_hazard; s_addr = ex2mem_wb_reg_addr;
        n_req += int'(mem_req); n_stall += int'(ex_stall); n_err += int'(mem_err);
        to      = m_busy && !mem_ready && (m_waited == TO - 1);
        e_stall = m_busy && !mem_ready && !to;
        e_valid = m_valid && !to;
        e_addr  = to ? '0 : m_addr;
        e_haz   = e_valid && (m_src == SRC_MEM) && (e_addr == alu_opr_reg_addr) && (alu_opr_reg_addr != '0);
        chk("valid", 32'(ex2mem_valid), 32'(e_valid));
        chk("wb_reg_addr", 32'(ex2mem_wb_reg_addr), 32'(e_addr));
        chk("alu_result", ex2mem_alu_result, m_alu);
        chk("wb_src", 32'(ex2mem_wb_src), 32'(m_src));
        chk("mem_wr", 32'(ex2mem_mem_wr), 32'(m_wr));
        chk("store_data", ex2mem_store_data, m_sd);
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        chk("ex_stall", 32'(ex_stall), 32'(e_stall));
        chk("mem_err", 32'(mem_err), 32'(to));
        chk("load_hazard", 32'(load_hazard), 32'(e_haz));
`ifdef STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall_total);
`endif
        if (e_stall) begin
            m_waited++;
            m_stall_total++;
        end else begin
            m_waited = 0;
            if (ex_valid && !flush) begin
                m_valid = 1'b1; m_alu = ex_alu_result; m_addr = ex_wb_reg_addr;
                m_src = ex_wb_src; m_wr = ex_mem_wr; m_sd = ex_store_data;
                m_busy = (ex_wb_src == SRC_MEM) || ex_mem_wr;
            end else begin
                m_valid = 1'b0; m_alu = '0; m_addr = '0; m_src = '0; m_wr = 1'b0; m_sd = '0;
                m_busy = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_counts();
        n_req = 0; n_stall = 0; n_err = 0;
    endtask

    initial begin
        model_reset();
        clear_counts();
        rst_n = 1'b0;
        drive(0, 0, 0, SRC_ALU, 0, 0, 0, 0, 0);
        #2;
        chk("reset_valid", 32'(ex2mem_valid), 32'd0);
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_err", 32'(mem_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU op to r5 lands in the register one edge later with no memory traffic.
        drive(1, 0, 5, SRC_ALU, 0, 32'h1234, 0, 0, 0);
        cycle();
        drive(0, 0, 0, SRC_ALU, 0, 0, 0, 0, 0);
        cycle();
        chk("alu_op_valid", 32'(s_valid), 32'd1);
        chk("alu_op_addr", 32'(s_addr), 32'd5);
        chk("alu_op_req", 32'(s_req), 32'd0);

        // Load r3, ready on the third WAIT cycle; next instruction r7 queued behind it.
        drive(1, 0, 3, SRC_MEM, 0, 32'h100, 0, 0, 0);
        cycle();
        clear_counts();
        drive(1, 0, 7, SRC_ALU, 0, 32'hAA, 0, 0, 3);
        cycle();
        chk("hazard_r3", 32'(s_hazard), 32'd1);
        drive(1, 1, 7, SRC_ALU, 0, 32'hAA, 0, 0, 0);
        cycle();
        chk("hazard_r0", 32'(s_hazard), 32'd0);
        chk("flush_in_wait_req", 32'(s_req), 32'd1);
        drive(1, 0, 7, SRC_ALU, 0, 32'hAA, 0, 1, 0);
        cycle();
        chk("load_req_cycles", 32'(n_req), 32'd3);
        chk("load_stall_cycles", 32'(n_stall), 32'd2);
        drive(1, 1, 9, SRC_ALU, 0, 32'h55, 0, 0, 0);
        cycle();
        chk("next_loaded_addr", 32'(s_addr), 32'd7);
        drive(0, 0, 0, SRC_ALU, 0, 0, 0, 0, 0);
        cycle();
        chk("flush_bubble_valid", 32'(s_valid), 32'd0);
        chk("flush_bubble_addr", 32'(s_addr), 32'd0);

        // Load r9 that never sees mem_ready: aborts after TO WAIT cycles.
        drive(1, 0, 9, SRC_MEM, 0, 32'h200, 0, 0, 0);
        cycle();
        clear_counts();
        drive(0, 0, 0, SRC_ALU, 0, 0, 0, 0, 9);
        repeat (TO) cycle();
        chk("timeout_err_pulses", 32'(n_err), 32'd1);
        chk("timeout_last_err", 32'(s_err), 32'd1);
        chk("timeout_last_valid", 32'(s_valid), 32'd0);
        chk("timeout_last_stall", 32'(s_stall), 32'd0);
        chk("timeout_stall_cycles", 32'(n_stall), 32'(TO - 1));
        cycle();
        chk("after_timeout_req", 32'(s_req), 32'd0);

        // Reset in the middle of a WAIT cycle clears everything without an edge.
        drive(1, 0, 4, SRC_MEM, 1, 32'h300, 32'hDEAD, 0, 0);
        cycle();
        drive(0, 0, 0, SRC_ALU, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ex2mem_valid), 32'd0);
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_err", 32'(mem_err), 32'd0);
        chk("async_rst_stall", 32'(ex_stall), 32'd0);
        chk("async_rst_alu", ex2mem_alu_result, 32'd0);
`ifdef STALL_CNT_EN
        chk("async_rst_stall_cnt", stall_cnt, 32'd0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 6, SRC_MEM, 0, 32'h400, 0, 0, 0);
        cycle();
        drive(0, 0, 0, SRC_ALU, 0, 0, 0, 1, 6);
        cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7), SW'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                  $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
